ring_osc2x13: RTL and testbench

RING_OSC2X13 -- requirements
Module: ring_osc2x13

---
 rtl/ring_osc2x13_pkg.sv | 25 ++
 rtl/ring_osc2x13_if.sv | 15 +
 rtl/ring_osc_stage.sv | 35 +++
 rtl/ring_osc2x13.sv | 52 +++++
 tb/tb_ring_osc2x13.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/ring_osc2x13_pkg.sv
// Shared constants and trim-bit mapping for the 13-stage trimmed ring oscillator.
`timescale 1ns/1ps
package ring_osc2x13_pkg;

  localparam int unsigned STAGES        = 13;
  localparam int unsigned BASE_DELAY_PS = 50;
  localparam int unsigned TRIM_STEP_PS  = 10;
  localparam int unsigned TRIM_W        = 2 * STAGES;

  // Stage k owns two equally weighted trim bits: k and k + stages.
  function automatic int unsigned trim_lo(input int unsigned k);
    return k;
  endfunction

  function automatic int unsigned trim_hi(input int unsigned k, input int unsigned stages);
    return k + stages;
  endfunction

  function automatic int unsigned stage_delay_ps(input int unsigned base,
                                                 input int unsigned step,
                                                 input logic [1:0]  t);
    return base + step * (32'(t[0]) + 32'(t[1]));
  endfunction

endpackage

// File: rtl/ring_osc2x13_if.sv
// Trim/tap bundle for drivers and observers of ring_osc2x13.
`timescale 1ns/1ps
interface ring_osc2x13_if
  import ring_osc2x13_pkg::*;
#(
  parameter int unsigned W = TRIM_W
) ();

  logic [W-1:0] trim;
  logic [1:0]   clockp;

  modport master (output trim, input clockp);
  modport slave  (input trim, output clockp);

endinterface

// File: rtl/ring_osc_stage.sv
// One inverting delay element of the ring; behavioral, delay set by two trim bits.
`timescale 1ns/1ps
module ring_osc_stage
  import ring_osc2x13_pkg::*;
#(
  parameter bit          INIT          = 1'b0,
  parameter bit          KICK          = 1'b0,
  parameter int unsigned BASE_DELAY_PS = ring_osc2x13_pkg::BASE_DELAY_PS,
  parameter int unsigned TRIM_STEP_PS  = ring_osc2x13_pkg::TRIM_STEP_PS
) (
  input  logic       a,
  input  logic [1:0] trim,
  output logic       y
);

  function automatic realtime delay_ns(input logic [1:0] t);
    return real'(stage_delay_ps(BASE_DELAY_PS, TRIM_STEP_PS, t)) / 1000.0;
  endfunction

  // Delay is taken from trim when a transition starts, so trim changes land on the
  // next transition. Output is rewritten from ~a, so spurious start-up events are harmless.
  always begin
    y = INIT;
    if (KICK) begin
      #(delay_ns(trim));
      y = ~a;
    end
    forever begin
      @(a);
      #(delay_ns(trim));
      y = ~a;
    end
  end

endmodule

// File: rtl/ring_osc2x13.sv
// 13-stage trimmed ring oscillator with two reset-gated taps; behavioral timing model.
`timescale 1ns/1ps
module ring_osc2x13
  import ring_osc2x13_pkg::*;
#(
  parameter int unsigned STAGES        = ring_osc2x13_pkg::STAGES,
  parameter int unsigned BASE_DELAY_PS = ring_osc2x13_pkg::BASE_DELAY_PS,
  parameter int unsigned TRIM_STEP_PS  = ring_osc2x13_pkg::TRIM_STEP_PS
) (
  input  logic                  reset,
  input  logic [2*STAGES-1:0]   trim,
  output logic [1:0]            clockp
);

  localparam int unsigned MID = STAGES / 2;

  logic [STAGES-1:0] n;
  logic              rst_q;
  logic              en0;
  logic              en1;

  // Start state n_k = k mod 2 leaves only stage 0 unstable: one edge circulates.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    ring_osc_stage #(
      .INIT          ((k % 2) == 1),
      .KICK          (k == 0),
      .BASE_DELAY_PS (BASE_DELAY_PS),
      .TRIM_STEP_PS  (TRIM_STEP_PS)
    ) u_stage (
      .a    (n[(k + STAGES - 1) % STAGES]),
      .trim ({trim[trim_hi(k, STAGES)], trim[trim_lo(k)]}),
      .y    (n[k])
    );
  end

  always_ff @(posedge n[STAGES-1]) begin
    rst_q <= reset;
  end

  // Tap enables follow ~rst_q but only change while their tap is low, so a gated
  // tap always emits whole pulses; a late reset is caught at the falling edge.
  always_ff @(negedge n[STAGES-1]) begin
    en0 <= ~(rst_q | reset);
  end

  always_ff @(negedge n[MID]) begin
    en1 <= ~(rst_q | reset);
  end

  assign clockp = {n[MID] & en1, n[STAGES-1] & en0};

endmodule

// File: tb/tb_ring_osc2x13.sv
// Directed bench for ring_osc2x13: reset gating, trim-to-period law, runt and stall checks.
`timescale 1ns/1ps
module tb_ring_osc2x13;
  import ring_osc2x13_pkg::*;

  localparam int P0   = 1300;
  localparam int STEP = 20;

  logic reset;
  ring_osc2x13_if bus ();

  ring_osc2x13 #(
    .STAGES        (13),
    .BASE_DELAY_PS (50),
    .TRIM_STEP_PS  (10)
  ) dut (
    .reset  (reset),
    .trim   (bus.trim),
    .clockp (bus.clockp)
  );

  int      checks = 0;
  int      passed = 0;
  int      fails  = 0;
  int      exp_q[$];

  realtime t0_last = 0.0, t0_prev = 0.0, t1_last = 0.0, t1_prev = 0.0;
  int      cnt0 = 0, cnt1 = 0;
  int      runts0 = 0, runts1 = 0;
  bit      tog_active = 1'b0;
  int      tog_edges = 0, tog_bad = 0;

  function automatic int ps_of(input realtime d);
    return int'(d * 1000.0);
  endfunction

  always @(posedge bus.clockp[0]) begin
    t0_prev = t0_last;
    t0_last = $realtime;
    cnt0++;
  end

  always @(negedge bus.clockp[0]) begin
    if ($realtime - t0_last < 0.640) runts0++;
  end

  always @(posedge bus.clockp[1]) begin
    t1_prev = t1_last;
    t1_last = $realtime;
    cnt1++;
    if (tog_active) begin
      tog_edges++;
      if (ps_of(t1_last - t1_prev) < 1300 || ps_of(t1_last - t1_prev) > 1820) tog_bad++;
    end
  end

  always @(negedge bus.clockp[1]) begin
    if ($realtime - t1_last < 0.640) runts1++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic measure(input bit tap, output int ps);
    int c0;
    int n;
    c0 = tap ? cnt1 : cnt0;
    n  = 0;
    while ((tap ? cnt1 : cnt0) < c0 + 2 && n < 400) begin
      #0.05;
      n++;
    end
    if (n >= 400) ps = -1;
    else ps = tap ? ps_of(t1_last - t1_prev) : ps_of(t0_last - t0_prev);
  endtask

  task automatic chk_period(input string tag, input bit tap, output int got);
    int e;
    measure(tap, got);
    e = exp_q.pop_front();
    chk(tag, got, e);
  endtask

  task automatic watch_low(input string tag, input int steps);
    int highs;
    highs = 0;
    for (int i = 0; i < steps; i++) begin
      if (bus.clockp !== 2'b00) highs++;
      #0.1;
    end
    chk(tag, highs, 0);
  endtask

  initial begin
    int          got, prev, g_lsb, g_msb, base_e, base_b;
    logic [25:0] tv;

    reset    = 1'b1;
    bus.trim = '0;
    watch_low("reset_hold", 200);

    reset = 1'b0;
    exp_q.push_back(P0);
    exp_q.push_back(P0);
    #200;
    chk_period("untrimmed_tap1", 1'b1, got);
    chk_period("untrimmed_tap0", 1'b0, got);

    prev = P0;
    tv   = '0;
    for (int unsigned i = 0; i < 26; i++) begin
      tv[i]    = 1'b1;
      bus.trim = tv;
      exp_q.push_back(P0 + STEP * int'(i + 1));
      #100;
      chk_period($sformatf("cum_trim_%0d", i), 1'b1, got);
      chk($sformatf("freq_drop_%0d", i), int'(got > prev), 1);
      prev = got;
    end

    bus.trim = 26'h0000001;
    exp_q.push_back(1320);
    #100;
    chk_period("pos_lsb", 1'b1, g_lsb);
    bus.trim = 26'h2000000;
    exp_q.push_back(1320);
    #100;
    chk_period("pos_msb", 1'b1, g_msb);
    chk("pos_equal", g_msb, g_lsb);

    bus.trim = 26'h0000FFF;
    exp_q.push_back(1540);
    #100;
    chk_period("pre_reset", 1'b1, got);
    #0.337;
    reset = 1'b1;
    #1.545;
    watch_low("reset_mid", 200);
    reset = 1'b0;
    exp_q.push_back(1540);
    exp_q.push_back(1540);
    #100;
    chk_period("resume_tap1", 1'b1, got);
    chk_period("resume_tap0", 1'b0, got);

    base_e     = tog_edges;
    base_b     = tog_bad;
    tog_active = 1'b1;
    for (int i = 0; i < 72; i++) begin
      #0.7;
      bus.trim = bus.trim ^ (26'd1 << $urandom_range(25, 0));
    end
    tog_active = 1'b0;
    chk("toggle_range", tog_bad - base_b, 0);
    chk("toggle_no_stall", int'((tog_edges - base_e) >= 26), 1);

    exp_q.push_back(P0 + STEP * $countones(bus.trim));
    #100;
    chk_period("toggle_settled", 1'b1, got);

    chk("no_runt_tap0", runts0, 0);
    chk("no_runt_tap1", runts1, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
